// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state type and synchronizer depth.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_DESEL
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with one extra flop so that
// single-cycle rise/fall pulses can be derived from the synchronized level.
module spi_sync_edge
  import spi_pkg::*;
(
  input  logic clk,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  // No reset here: the chain just follows the pin, so after any reset the
  // synchronized level already reflects the true pin state.
  logic [SYNC_STAGES-1:0] stage_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    stage_reg <= {stage_reg[SYNC_STAGES-2:0], din};
    prev_reg  <= stage_reg[SYNC_STAGES-1];
  end

  assign sync = stage_reg[SYNC_STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder, MSB first, fully oversampled on clock_i.
// Define SPI_TARGET_ERR_EN to generate the frame_err_o / tx_underrun_o pulses.
module spi_target
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [WORD_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [WORD_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  frame_err_o,
  output logic                  tx_underrun_o
);

  localparam int CW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

  // Bit 0 carries sclk, bit 1 carries cs_n.
  logic [1:0] pin_raw, pin_sync, pin_rise, pin_fall;
  assign pin_raw = {cs_n_i, sclk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_pin_sync
    spi_sync_edge u_sync (
      .clk  (clock_i),
      .din  (pin_raw[gi]),
      .sync (pin_sync[gi]),
      .rise (pin_rise[gi]),
      .fall (pin_fall[gi])
    );
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_level;
  logic unused_sclk_level;
  assign sclk_rise         = pin_rise[0];
  assign sclk_fall         = pin_fall[0];
  assign cs_rise           = pin_rise[1];
  assign cs_fall           = pin_fall[1];
  assign cs_level          = pin_sync[1];
  assign unused_sclk_level = pin_sync[0];

  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  always_ff @(posedge clock_i) begin
    mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi_i};
  end

  state_t                  state_reg;
  logic [CW-1:0]           count_reg;
  logic [WORD_WIDTH-1:0]   tx_shift_reg;
  logic [WORD_WIDTH-2:0]   rx_shift_reg;
  logic [WORD_WIDTH-1:0]   tx_buf_reg;
  logic                    tx_full_reg;
  logic                    miso_reg;
  logic                    miso_oe_reg;
  logic [WORD_WIDTH-1:0]   rx_data_reg;
  logic                    rx_valid_reg;

  logic                    word_start;
  logic                    tx_accept;
  logic [WORD_WIDTH-1:0]   tx_load;
  logic [WORD_WIDTH-1:0]   rx_word;

  always_comb begin
    word_start = 1'b0;
    if (state_reg == IDLE && cs_fall) begin
      word_start = 1'b1;
    end else if (state_reg == SHIFT && !cs_rise && sclk_fall && count_reg == '0) begin
      word_start = 1'b1;
    end
    // The word start uses the buffer state from before this cycle's handshake.
    tx_accept = tx_valid_i & ~tx_full_reg;
    tx_load   = tx_full_reg ? tx_buf_reg : '0;
    rx_word   = {rx_shift_reg, mosi_sync_reg[SYNC_STAGES-1]};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg    <= WAIT_DESEL;
      count_reg    <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      tx_buf_reg   <= '0;
      tx_full_reg  <= 1'b0;
      miso_reg     <= 1'b0;
      miso_oe_reg  <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;

      if (word_start) begin
        tx_shift_reg <= tx_load;
        miso_reg     <= tx_load[WORD_WIDTH-1];
      end

      if (word_start && tx_full_reg) begin
        tx_full_reg <= 1'b0;
      end else if (tx_accept) begin
        tx_buf_reg  <= tx_data_i;
        tx_full_reg <= 1'b1;
      end

      case (state_reg)
        WAIT_DESEL: begin
          if (cs_level) state_reg <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state_reg   <= SHIFT;
            count_reg   <= '0;
            miso_oe_reg <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            // A partial word is simply dropped; the shifter is refilled by the next frame.
            state_reg   <= IDLE;
            count_reg   <= '0;
            miso_oe_reg <= 1'b0;
            miso_reg    <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift_reg <= rx_word[WORD_WIDTH-2:0];
              if (count_reg == LAST_BIT) begin
                rx_data_reg  <= rx_word;
                rx_valid_reg <= 1'b1;
                count_reg    <= '0;
              end else begin
                count_reg <= count_reg + CW'(1);
              end
            end
            if (sclk_fall && count_reg != '0) begin
              tx_shift_reg <= {tx_shift_reg[WORD_WIDTH-2:0], 1'b0};
              miso_reg     <= tx_shift_reg[WORD_WIDTH-2];
            end
          end
        end
        default: state_reg <= WAIT_DESEL;
      endcase
    end
  end

`ifdef SPI_TARGET_ERR_EN
  logic frame_err_reg;
  logic tx_underrun_reg;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      frame_err_reg   <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      frame_err_reg   <= (state_reg == SHIFT) && cs_rise && (count_reg != '0);
      tx_underrun_reg <= word_start && !tx_full_reg;
    end
  end

  assign frame_err_o   = frame_err_reg;
  assign tx_underrun_o = tx_underrun_reg;
`else
  assign frame_err_o   = 1'b0;
  assign tx_underrun_o = 1'b0;
`endif

  assign miso_o     = miso_reg;
  assign miso_oe_o  = miso_oe_reg;
  assign tx_ready_o = ~tx_full_reg;
  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;

endmodule
